ram_sdp_be: RTL and testbench
=============================

// Module: ram_sdp_be
// PURPOSE
//  Simple dual-port synchronous RAM: one write port, one read port, byte enables.
//  Successor to the single-port tri-state RAM, with separate read and write buses.
//  Adds a post-reset clear sequence, a configurable read latency and a selectable read-during-write mode.
//  Used as the general-purpose buffer and register-file store in the datapath.
// PARAMETERS
//  DATA_WIDTH  8              word width in bits; must be a multiple of 8
//  ADDR_WIDTH  8              address width
//  RAM_DEPTH   1<<ADDR_WIDTH  number of words; must be <= 2**ADDR_WIDTH
//  READ_LAT    1              read latency in cycles; only 1 or 2 allowed (2 = extra output register)
//  RDW_MODE    0              same-address read during write: 0 = old data, 1 = new data
//  INIT_VALUE  0              word written to every location by the clear sequence
// PORTS
//  clk       in   1             clock; all logic on posedge
//  rst       in   1             synchronous, active-high reset
//  wr_en     in   1             write request
//  wr_addr   in   ADDR_WIDTH    write address
//  wr_data   in   DATA_WIDTH    write data
//  wr_be     in   DATA_WIDTH/8  byte enables; bit i enables wr_data[8i+7:8i]
//  rd_en     in   1             read request
//  rd_addr   in   ADDR_WIDTH    read address
//  rd_data   out  DATA_WIDTH    read data; valid when rd_valid=1
//  rd_valid  out  1             1-cycle pulse, READ_LAT cycles after an accepted read
//  init_busy out  1             1 while the clear sequence runs; requests are ignored
// BEHAVIOUR
//  - Reset:
//    - Any posedge with rst=1: state<=INIT, clr_cnt<=0.
//    - rd_valid and the whole read pipeline <=0; rd_data<=0.
//    - Reset during INIT restarts the clear sequence at address 0.
//  - State machine, states INIT and RUN:
//    - INIT: each posedge with rst=0 writes INIT_VALUE (all bytes) to mem[clr_cnt], then clr_cnt<=clr_cnt+1.
//    - When clr_cnt==RAM_DEPTH-1 is written, state<=RUN.
//    - Clear takes exactly RAM_DEPTH edges after reset release.
//    - RUN has no exit except rst.
//  - init_busy = (state==INIT). Combinational from state; it is 1 during reset as well.
//  - During INIT, wr_en and rd_en are ignored: no write, rd_valid stays 0.
//  - Write (RUN, wr_en=1):
//    - At the posedge, each byte i with wr_be[i]=1 is updated; other bytes are kept.
//    - wr_be=0 is a no-op.
//  - Read (RUN, rd_en=1), READ_LAT=1:
//    - rd_data<=mem[rd_addr] at the same edge that samples rd_en; rd_valid=1 for the following cycle.
//  - READ_LAT=2: adds one register stage; data and valid appear one cycle later and stay aligned.
//  - Reads issue back-to-back every cycle; throughput is 1 read/cycle.
//  - rd_data holds its last value when no read completes.
//  - Simultaneous rd/wr to the same address:
//    - RDW_MODE=0: return the pre-write word.
//    - RDW_MODE=1: return the pre-write word with enabled bytes replaced by wr_data (bypass merge).
//  - Simultaneous rd/wr to different addresses: independent, no stall.
//  - Address >= RAM_DEPTH: writes are dropped; reads return 0 with rd_valid=1.
//  - rst asserted with reads in flight: pending rd_valid pulses are cancelled.
// STRUCTURE
//  - Package ram_pkg:
//    - state enum {RAM_INIT, RAM_RUN};
//    - constants RDW_OLD=0, RDW_NEW=1;
//    - function be_merge(old, new, be) returning the byte-merged word.
//  - Sub-module ram_sdp_core: the bare storage array with byte-enable write and registered read.
//  - Top holds: the FSM, the clear counter, the write mux (clear vs user), the RDW bypass and the latency pipeline.
// TESTING
//  1. rst=1 for 2 cycles, then 0, with ADDR_WIDTH=4 and INIT_VALUE=8'hA5.
//     -> init_busy=1 for exactly 16 edges.
//     -> reads of addresses 0..15 then all return 8'hA5.
//  2. Write 8'h3C to address 5 with wr_be=1, then read address 5.
//     -> READ_LAT=1: rd_valid=1 and rd_data=8'h3C one cycle after rd_en.
//     -> READ_LAT=2: the same, two cycles after rd_en.
//  3. DATA_WIDTH=16, mem[2]=16'h1234.
//     -> write 16'hABCD with wr_be=2'b01; read address 2 returns 16'h12CD.
//     -> write with wr_be=2'b00; read returns 16'h12CD unchanged.
//  4. mem[7]=8'h11; write 8'h22 to address 7 and read address 7 in the same cycle.
//     -> RDW_MODE=0 returns 8'h11; RDW_MODE=1 returns 8'h22.
//     -> a subsequent read returns 8'h22 in both modes.
//  5. Assert rst halfway through the clear sequence.
//     -> clr_cnt restarts at 0; init_busy stays 1 for a full RAM_DEPTH edges after release.
//  6. rd_en and wr_en asserted during INIT: no write occurs and rd_valid stays 0.
//     Then, with READ_LAT=2, assert rst while reads are in flight.
//     -> rd_valid stays 0 until a new read is accepted in RUN.

Source files
------------

// File: rtl/ram_sdp_be_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable RAM.
package ram_pkg;

   typedef enum logic {RAM_INIT, RAM_RUN} ram_state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int BM_W = 256;
   localparam int BM_B = BM_W / 8;

   function automatic logic [BM_W-1:0] be_merge(input logic [BM_W-1:0] old_w,
                                                input logic [BM_W-1:0] new_w,
                                                input logic [BM_B-1:0] be);
      logic [BM_W-1:0] res;
      res = old_w;
      for (int i = 0; i < BM_B; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_sdp_be_core.sv
// Bare storage array: byte-enable write port and a registered, read-before-write read port.
module ram_sdp_core #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte enables, post-reset clear, 1/2-cycle read latency
// and selectable read-during-write behaviour.
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int READ_LAT   = 1,
   parameter int RDW_MODE   = RDW_OLD,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    init_busy
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

   logic                  wr_in, rd_in, rd_acc;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_wbe;
   logic [DATA_WIDTH-1:0] core_rdata;

   logic [2:1]            vld_pipe_q, vld_pipe_d;
   logic                  hit_q, hit_d, oor_q, oor_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
   logic [NB-1:0]         byp_be_q, byp_be_d;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

   assign wr_in = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in = {1'b0, rd_addr} < DEPTH_W;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RAM_INIT;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == RAM_INIT) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == LAST) state_d = RAM_RUN;
      end
   end

   // FSM: outputs, including the clear-vs-user write mux
   always_comb begin
      init_busy = (state_q == RAM_INIT);
      rd_acc    = rd_en && (state_q == RAM_RUN) && !rst;
      mem_we    = wr_en && (state_q == RAM_RUN) && !rst && wr_in;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_wbe   = wr_be;
      if (state_q == RAM_INIT) begin
         mem_we    = !rst;
         mem_waddr = clr_cnt_q;
         mem_wdata = INIT_VALUE;
         mem_wbe   = '1;
      end
   end

   ram_sdp_core #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .RAM_DEPTH (RAM_DEPTH)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .we   (mem_we),
      .waddr(mem_waddr),
      .wdata(mem_wdata),
      .wbe  (mem_wbe),
      .re   (rd_acc && rd_in),
      .raddr(rd_addr),
      .rdata(core_rdata)
   );

   // Sideband captured alongside each accepted read; held otherwise so rd_data holds.
   always_comb begin
      vld_pipe_d = {vld_pipe_q[1], rd_acc};
      hit_d      = hit_q;
      oor_d      = oor_q;
      byp_data_d = byp_data_q;
      byp_be_d   = byp_be_q;
      if (rd_acc) begin
         hit_d      = (RDW_MODE == RDW_NEW) && wr_en && (wr_addr == rd_addr);
         oor_d      = !rd_in;
         byp_data_d = wr_data;
         byp_be_d   = wr_be;
      end
   end

   always_comb begin
      s1_data = core_rdata;
      if (oor_q)
         s1_data = '0;
      else if (hit_q)
         s1_data = DATA_WIDTH'(be_merge(BM_W'(core_rdata), BM_W'(byp_data_q), BM_B'(byp_be_q)));
   end

   always_comb begin
      rd_data2_d = rd_data2_q;
      if (vld_pipe_q[1]) rd_data2_d = s1_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         hit_q      <= 1'b0;
         oor_q      <= 1'b0;
         byp_data_q <= '0;
         byp_be_q   <= '0;
         rd_data2_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         hit_q      <= hit_d;
         oor_q      <= oor_d;
         byp_data_q <= byp_data_d;
         byp_be_q   <= byp_be_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   always_comb begin
      rd_valid = (READ_LAT == 2) ? vld_pipe_q[2] : vld_pipe_q[1];
      rd_data  = (READ_LAT == 2) ? rd_data2_q    : s1_data;
   end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Two RAM configurations driven in lockstep, each checked every cycle against a word-level model.
module tb_ram_sdp_be;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en;
   logic [3:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic [7:0]  rd_data0;
   logic [15:0] rd_data1;
   logic        rd_valid0, rd_valid1, busy0, busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_sdp_be #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LAT(1),
                .RDW_MODE(0), .INIT_VALUE(8'hA5)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
      .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .init_busy(busy0));

   ram_sdp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RAM_DEPTH(12), .READ_LAT(2),
                .RDW_MODE(1), .INIT_VALUE(16'h5AA5)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .init_busy(busy1));

   // ---------------- behavioural model ----------------
   localparam int          DW_M[2]    = '{8, 16};
   localparam int          DEPTH_M[2] = '{16, 12};
   localparam int          LAT_M[2]   = '{1, 2};
   localparam int          RDW_M[2]   = '{0, 1};
   localparam logic [15:0] INIT_M[2]  = '{16'h00A5, 16'h5AA5};

   typedef struct { int id; int due; logic [15:0] d; } pend_t;

   pend_t       pq[$];
   logic [15:0] mem_m [2][16];
   bit          busy_m[2];
   int          cnt_m[2];
   bit          ev[2];
   logic [15:0] ed[2] = '{16'h0, 16'h0};
   int          cyc_n  = 0;
   bit          chk_en = 0;

   task automatic model_step(input int i);
      logic [15:0] msk, wd, rdv;
      logic [1:0]  be;
      msk = (DW_M[i] == 8) ? 16'h00FF : 16'hFFFF;
      wd  = wr_data & msk;
      be  = (DW_M[i] == 8) ? {1'b0, wr_be[0]} : wr_be;
      ev[i] = 1'b0;
      if (rst) begin
         for (int k = pq.size() - 1; k >= 0; k--) if (pq[k].id == i) pq.delete(k);
         ed[i] = '0; busy_m[i] = 1'b1; cnt_m[i] = 0;
         return;
      end
      if (busy_m[i]) begin
         mem_m[i][cnt_m[i]] = INIT_M[i];
         cnt_m[i]++;
         if (cnt_m[i] == DEPTH_M[i]) busy_m[i] = 1'b0;
      end else begin
         if (rd_en) begin
            rdv = '0;
            if (int'(rd_addr) < DEPTH_M[i]) begin
               rdv = mem_m[i][rd_addr];
               if (RDW_M[i] == 1 && wr_en && wr_addr == rd_addr)
                  for (int b = 0; b < 2; b++) if (be[b]) rdv[8*b +: 8] = wd[8*b +: 8];
            end
            pq.push_back('{i, cyc_n + LAT_M[i] - 1, rdv});
         end
         if (wr_en && int'(wr_addr) < DEPTH_M[i])
            for (int b = 0; b < 2; b++) if (be[b]) mem_m[i][wr_addr][8*b +: 8] = wd[8*b +: 8];
      end
      for (int k = 0; k < pq.size(); k++)
         if (pq[k].id == i && pq[k].due == cyc_n) begin
            ev[i] = 1'b1; ed[i] = pq[k].d; pq.delete(k); break;
         end
   endtask

   always @(posedge clk) begin
      cyc_n++;
      if (rst) chk_en = 1'b1;
      model_step(0);
      model_step(1);
   end

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Compare process: every cycle, both DUTs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         lit("busy0",  {31'b0, busy0},     {31'b0, busy_m[0]});
         lit("valid0", {31'b0, rd_valid0}, {31'b0, ev[0]});
         lit("data0",  {24'b0, rd_data0},  {16'b0, ed[0]});
         lit("busy1",  {31'b0, busy1},     {31'b0, busy_m[1]});
         lit("valid1", {31'b0, rd_valid1}, {31'b0, ev[1]});
         lit("data1",  {16'b0, rd_data1},  {16'b0, ed[1]});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic op(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input bit re, input logic [3:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // Called right after op() issued a read: dut0 answers now, dut1 one cycle later.
   task automatic lit_rd(input string nm, input logic [7:0] e0, input logic [15:0] e1);
      lit({nm, "_v0"}, {31'b0, rd_valid0}, 32'd1);
      lit({nm, "_d0"}, {24'b0, rd_data0}, {24'b0, e0});
      @(negedge clk);
      lit({nm, "_v1"}, {31'b0, rd_valid1}, 32'd1);
      lit({nm, "_d1"}, {16'b0, rd_data1}, {16'b0, e1});
   endtask

   // Measures init_busy length from reset release; requests are dropped once either DUT leaves INIT.
   task automatic busy_len(input string nm, input int e0, input int e1);
      int n0 = 0, n1 = 0, nv = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy0) n0++;
         if (busy1) n1++;
         if (rd_valid0 || rd_valid1) nv++;
         if (!busy0 || !busy1) begin wr_en = 1'b0; rd_en = 1'b0; end
         @(negedge clk);
      end
      lit({nm, "_len0"}, n0, e0);
      lit({nm, "_len1"}, n1, e1);
      lit({nm, "_novalid"}, nv, 0);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
      repeat (2) @(negedge clk);

      // clear length, with requests held during INIT
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 4'd0;
      busy_len("init", 16, 12);
      op(0, 0, 0, 0, 1, 4'd0);  lit_rd("init_rd", 8'hA5, 16'h5AA5);
      for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a));
      repeat (2) @(negedge clk);

      // single-byte write then read
      op(1, 4'd5, 16'h003C, 2'b01, 0, 0);
      op(0, 0, 0, 0, 1, 4'd5);  lit_rd("wr5", 8'h3C, 16'h5A3C);

      // partial byte enables and the no-op write
      op(1, 4'd2, 16'h1234, 2'b11, 0, 0);
      op(1, 4'd2, 16'hABCD, 2'b01, 0, 0);
      op(0, 0, 0, 0, 1, 4'd2);  lit_rd("be01", 8'hCD, 16'h12CD);
      op(1, 4'd2, 16'hFFFF, 2'b00, 0, 0);
      op(0, 0, 0, 0, 1, 4'd2);  lit_rd("be00", 8'hCD, 16'h12CD);

      // read during write: dut0 old data, dut1 bypass
      op(1, 4'd7, 16'h0011, 2'b11, 0, 0);
      op(1, 4'd7, 16'h0022, 2'b11, 1, 4'd7);  lit_rd("rdw", 8'h11, 16'h0022);
      op(0, 0, 0, 0, 1, 4'd7);  lit_rd("rdw_after", 8'h22, 16'h0022);

      // address 13 exists in dut0 only
      op(1, 4'd13, 16'hBEEF, 2'b11, 0, 0);
      op(0, 0, 0, 0, 1, 4'd13); lit_rd("oor", 8'hEF, 16'h0000);

      // randomized traffic, biased toward same-address collisions
      for (int n = 0; n < 600; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = 16'($urandom);
         wr_be   = 2'($urandom_range(0, 3));
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      repeat (3) @(negedge clk);

      // reset halfway through the clear restarts it
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      busy_len("restart", 16, 12);

      // reset with reads in flight cancels their pulses
      rd_en = 1'b1; rd_addr = 4'd1; @(negedge clk);
      rd_addr = 4'd2;               @(negedge clk);
      rd_en = 1'b0; rst = 1'b1;     @(negedge clk);
      rst = 1'b0;
      busy_len("cancel", 16, 12);
      op(0, 0, 0, 0, 1, 4'd7);  lit_rd("post_rst", 8'hA5, 16'h5AA5);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
